// File: rtl/rip_trap_unit_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, cause codes,
// reset vector and the operation/state encodings.
package rip_trap_unit_pkg;

    localparam logic [31:0] START_ADDR         = 32'h0000_8000;

    localparam logic [11:0] CSR_MTVEC          = 12'h305;
    localparam logic [11:0] CSR_MEPC           = 12'h341;
    localparam logic [11:0] CSR_MCAUSE         = 12'h342;

    localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
    localparam logic [31:0] CAUSE_ECALL        = 32'd11;

    typedef enum logic [2:0] {
        OP_CSRRW,
        OP_CSRRS,
        OP_CSRRC,
        OP_ECALL,
        OP_ILLEGAL,
        OP_MRET
    } trap_op_e;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_EXEC,
        TS_RESP
    } trap_state_e;

endpackage

// File: rtl/rip_trap_unit_csr_file.sv
// mtvec/mepc/mcause storage with a combinational read port, one write port
// and a trap-save port that updates mepc and mcause together.
module rip_trap_csr_file
    import rip_trap_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = START_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_hit,
    input  logic            wr_en,
    input  logic [11:0]     wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            save_en,
    input  logic [XLEN-1:0] save_pc,
    input  logic [XLEN-1:0] save_cause,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc
);

    logic [XLEN-1:0] mcause;

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (rd_addr)
            CSR_MTVEC:  rd_data = mtvec;
            CSR_MEPC:   rd_data = mepc;
            CSR_MCAUSE: rd_data = mcause;
            default:    rd_hit  = 1'b0;
        endcase
    end

    // Only direct-mode vectors and 4-byte aligned PCs exist, so bits [1:0] of
    // mtvec and mepc are hardwired to zero on every write path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec  <= MTVEC_RST;
            mepc   <= '0;
            mcause <= '0;
        end else if (save_en) begin
            mepc   <= {save_pc[XLEN-1:2], 2'b00};
            mcause <= save_cause;
        end else if (wr_en) begin
            case (wr_addr)
                CSR_MTVEC:  mtvec  <= {wr_data[XLEN-1:2], 2'b00};
                CSR_MEPC:   mepc   <= {wr_data[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause <= wr_data;
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/rip_trap_unit.sv
// Machine-mode trap/CSR execution unit: one request per IDLE->EXEC->RESP pass,
// CSR read-modify-write, trap entry and MRET redirects.
module rip_trap_unit
    import rip_trap_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = START_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_pc,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_csr_we,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_taken
);

    trap_state_e state, next_state;

    logic [2:0]      op_q;
    logic [XLEN-1:0] pc_q, wdata_q;
    logic [11:0]     addr_q;
    logic            we_q;

    logic [XLEN-1:0] rdata_q, rpc_q;
    logic            rv_q, trap_q;

    logic [XLEN-1:0] rd_data, mtvec, mepc, csr_new, save_cause;
    logic [XLEN-1:0] ex_rdata, ex_rpc;
    logic            rd_hit, csr_wr_en, save_en, ex_rv, ex_trap, is_csr, exec;

    rip_trap_csr_file #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (addr_q),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .wr_en      (csr_wr_en),
        .wr_addr    (addr_q),
        .wr_data    (csr_new),
        .save_en    (save_en),
        .save_pc    (pc_q),
        .save_cause (save_cause),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TS_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TS_IDLE: if (req_valid)  next_state = TS_EXEC;
            TS_EXEC:                 next_state = TS_RESP;
            TS_RESP: if (resp_ready) next_state = TS_IDLE;
            default:                 next_state = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (state == TS_IDLE && req_valid) begin
            op_q    <= req_op;
            pc_q    <= req_pc;
            addr_q  <= req_csr_addr;
            wdata_q <= req_wdata;
            we_q    <= req_csr_we;
        end
    end

    assign exec   = (state == TS_EXEC);
    assign is_csr = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);

    always_comb begin
        csr_new = wdata_q;
        case (op_q)
            OP_CSRRS: csr_new = rd_data | wdata_q;
            OP_CSRRC: csr_new = rd_data & ~wdata_q;
            default:  ;
        endcase
    end

    // Anything that is not a hit CSR op or MRET (unknown CSR, ILLEGAL, ECALL,
    // undefined encodings) takes the trap path; ECALL is the only non-illegal cause.
    always_comb begin
        csr_wr_en  = 1'b0;
        save_en    = 1'b0;
        save_cause = '0;
        ex_rdata   = '0;
        ex_rv      = 1'b0;
        ex_rpc     = '0;
        ex_trap    = 1'b0;
        if (is_csr && rd_hit) begin
            ex_rdata  = rd_data;
            csr_wr_en = exec && ((op_q == OP_CSRRW) || we_q);
        end else if (op_q == OP_MRET) begin
            ex_rv  = 1'b1;
            ex_rpc = mepc;
        end else begin
            save_en    = exec;
            save_cause = (op_q == OP_ECALL) ? CAUSE_ECALL : CAUSE_ILLEGAL_INST;
            ex_rv      = 1'b1;
            ex_trap    = 1'b1;
            ex_rpc     = mtvec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            rpc_q   <= '0;
            rv_q    <= 1'b0;
            trap_q  <= 1'b0;
        end else if (exec) begin
            rdata_q <= ex_rdata;
            rpc_q   <= ex_rpc;
            rv_q    <= ex_rv;
            trap_q  <= ex_trap;
        end
    end

    assign req_ready      = (state == TS_IDLE);
    assign resp_valid     = (state == TS_RESP);
    assign resp_rdata     = resp_valid ? rdata_q : '0;
    assign redirect_valid = resp_valid && rv_q;
    assign redirect_pc    = resp_valid ? rpc_q : '0;
    assign trap_taken     = resp_valid && trap_q;

endmodule

// File: tb/tb_rip_trap_unit.sv
// Self-checking bench for rip_trap_unit: directed scenarios plus randomized
// traffic compared against a behavioural CSR/trap model.
module tb_rip_trap_unit;
    import rip_trap_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_pc;
    logic [11:0] req_csr_addr;
    logic [31:0] req_wdata;
    logic        req_csr_we;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    int vectors;
    int miscompares;

    logic [31:0] m_mtvec, m_mepc, m_mcause;

    rip_trap_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_pc         (req_pc),
        .req_csr_addr   (req_csr_addr),
        .req_wdata      (req_wdata),
        .req_csr_we     (req_csr_we),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_taken     (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mtvec  = 32'h0000_8000;
        m_mepc   = 32'h0;
        m_mcause = 32'h0;
    endtask

    // Architectural effect of one request, from the CSR and trap rules.
    task automatic model(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] addr,
                         input logic [31:0] wd, input logic we,
                         output logic [31:0] e_rdata, output logic e_rv,
                         output logic [31:0] e_rpc, output logic e_trap);
        logic [31:0] old, nv;
        bit known;
        known   = (addr == 12'h305) || (addr == 12'h341) || (addr == 12'h342);
        e_rdata = 0; e_rv = 0; e_rpc = 0; e_trap = 0;
        if (op <= 3'd2 && known) begin
            old     = (addr == 12'h305) ? m_mtvec : (addr == 12'h341) ? m_mepc : m_mcause;
            e_rdata = old;
            if (op == 3'd0)      nv = wd;
            else if (op == 3'd1) nv = old | wd;
            else                 nv = old & ~wd;
            if (op == 3'd0 || we) begin
                if (addr == 12'h305)      m_mtvec  = nv & 32'hFFFF_FFFC;
                else if (addr == 12'h341) m_mepc   = nv & 32'hFFFF_FFFC;
                else                      m_mcause = nv;
            end
        end else if (op == 3'd5) begin
            e_rv  = 1;
            e_rpc = m_mepc;
        end else begin
            m_mepc   = pc & 32'hFFFF_FFFC;
            m_mcause = (op == 3'd3) ? 32'd11 : 32'd2;
            e_rv     = 1;
            e_trap   = 1;
            e_rpc    = m_mtvec;
        end
    endtask

    // Drives one request through the handshake, scrambling req_* after acceptance.
    task automatic run_req(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] addr,
                           input logic [31:0] wd, input logic we,
                           output int lat, output logic [31:0] o_rdata, output logic o_rv,
                           output logic [31:0] o_rpc, output logic o_trap);
        req_valid = 1; req_op = op; req_pc = pc; req_csr_addr = addr;
        req_wdata = wd; req_csr_we = we;
        @(posedge clk); #1;
        req_valid = 0;
        req_op = 3'($urandom); req_pc = $urandom; req_csr_addr = 12'($urandom);
        req_wdata = $urandom; req_csr_we = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        o_rdata = resp_rdata; o_rv = redirect_valid; o_rpc = redirect_pc; o_trap = trap_taken;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic read_csr(input logic [11:0] addr, output logic [31:0] val);
        logic [31:0] er, erp, orp; logic erv, et, orv, ot; int lat;
        logic [31:0] pc;
        pc = $urandom;
        model(OP_CSRRS, pc, addr, 32'hFFFF_FFFF, 1'b0, er, erv, erp, et);
        run_req(OP_CSRRS, pc, addr, 32'hFFFF_FFFF, 1'b0, lat, val, orv, orp, ot);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        vectors += 6;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        if (redirect_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_redirect_valid got %b want 0", redirect_valid); end
        if (trap_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_trap_taken got %b want 0", trap_taken); end
        if (resp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        if (redirect_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        read_csr(12'h305, v);
        vectors++;
        if (v !== 32'h0000_8000) begin miscompares++; $display("[TB] FAIL reset_mtvec got %h want 00008000", v); end
        read_csr(12'h341, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mepc got %h want 0", v); end
        read_csr(12'h342, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mcause got %h want 0", v); end
    endtask

    task automatic test_csrrw_mtvec();
        logic [31:0] er, erp, orr, orp, v; logic erv, et, orv, ot; int lat;
        model(OP_CSRRW, 32'h0000_8004, 12'h305, 32'h0000_9003, 1'b0, er, erv, erp, et);
        run_req(OP_CSRRW, 32'h0000_8004, 12'h305, 32'h0000_9003, 1'b0, lat, orr, orv, orp, ot);
        vectors += 4;
        if (lat !== 2) begin miscompares++; $display("[TB] FAIL csrrw_latency got %0d want 2", lat); end
        if (orr !== 32'h0000_8000) begin miscompares++; $display("[TB] FAIL csrrw_rdata got %h want 00008000", orr); end
        if (orv !== 1'b0) begin miscompares++; $display("[TB] FAIL csrrw_redirect_valid got %b want 0", orv); end
        if (ot !== 1'b0) begin miscompares++; $display("[TB] FAIL csrrw_trap got %b want 0", ot); end
        read_csr(12'h305, v);
        vectors++;
        if (v !== 32'h0000_9000) begin miscompares++; $display("[TB] FAIL csrrw_mtvec_new got %h want 00009000", v); end
    endtask

    task automatic test_csrrs_no_write();
        logic [31:0] er, erp, orr, orp, v; logic erv, et, orv, ot; int lat;
        model(OP_CSRRS, 32'h0000_8008, 12'h305, 32'h0000_00FF, 1'b0, er, erv, erp, et);
        run_req(OP_CSRRS, 32'h0000_8008, 12'h305, 32'h0000_00FF, 1'b0, lat, orr, orv, orp, ot);
        vectors++;
        if (orr !== 32'h0000_9000) begin miscompares++; $display("[TB] FAIL csrrs_rdata got %h want 00009000", orr); end
        read_csr(12'h305, v);
        vectors++;
        if (v !== 32'h0000_9000) begin miscompares++; $display("[TB] FAIL csrrs_no_write got %h want 00009000", v); end
    endtask

    task automatic test_ecall_mret();
        logic [31:0] er, erp, orr, orp, v; logic erv, et, orv, ot; int lat;
        model(OP_ECALL, 32'h0000_8010, 12'h0, 32'h0, 1'b0, er, erv, erp, et);
        run_req(OP_ECALL, 32'h0000_8010, 12'h0, 32'h0, 1'b0, lat, orr, orv, orp, ot);
        vectors += 5;
        if (lat !== 2) begin miscompares++; $display("[TB] FAIL ecall_latency got %0d want 2", lat); end
        if (orp !== 32'h0000_9000) begin miscompares++; $display("[TB] FAIL ecall_redirect_pc got %h want 00009000", orp); end
        if (orv !== 1'b1) begin miscompares++; $display("[TB] FAIL ecall_redirect_valid got %b want 1", orv); end
        if (ot !== 1'b1) begin miscompares++; $display("[TB] FAIL ecall_trap got %b want 1", ot); end
        if (orr !== 32'h0) begin miscompares++; $display("[TB] FAIL ecall_rdata got %h want 0", orr); end
        read_csr(12'h341, v);
        vectors++;
        if (v !== 32'h0000_8010) begin miscompares++; $display("[TB] FAIL ecall_mepc got %h want 00008010", v); end
        read_csr(12'h342, v);
        vectors++;
        if (v !== 32'd11) begin miscompares++; $display("[TB] FAIL ecall_mcause got %h want 0000000b", v); end
        model(OP_MRET, 32'h0000_9000, 12'h0, 32'h0, 1'b0, er, erv, erp, et);
        run_req(OP_MRET, 32'h0000_9000, 12'h0, 32'h0, 1'b0, lat, orr, orv, orp, ot);
        vectors += 3;
        if (orp !== 32'h0000_8010) begin miscompares++; $display("[TB] FAIL mret_redirect_pc got %h want 00008010", orp); end
        if (orv !== 1'b1) begin miscompares++; $display("[TB] FAIL mret_redirect_valid got %b want 1", orv); end
        if (ot !== 1'b0) begin miscompares++; $display("[TB] FAIL mret_trap got %b want 0", ot); end
    endtask

    task automatic test_unknown_csr();
        logic [31:0] er, erp, orr, orp, v; logic erv, et, orv, ot; int lat;
        model(OP_CSRRW, 32'h0000_8020, 12'h300, 32'hDEAD_BEEF, 1'b1, er, erv, erp, et);
        run_req(OP_CSRRW, 32'h0000_8020, 12'h300, 32'hDEAD_BEEF, 1'b1, lat, orr, orv, orp, ot);
        vectors += 3;
        if (ot !== 1'b1) begin miscompares++; $display("[TB] FAIL unknown_trap got %b want 1", ot); end
        if (orr !== 32'h0) begin miscompares++; $display("[TB] FAIL unknown_rdata got %h want 0", orr); end
        if (orp !== 32'h0000_9000) begin miscompares++; $display("[TB] FAIL unknown_redirect_pc got %h want 00009000", orp); end
        read_csr(12'h342, v);
        vectors++;
        if (v !== 32'd2) begin miscompares++; $display("[TB] FAIL unknown_mcause got %h want 00000002", v); end
        read_csr(12'h341, v);
        vectors++;
        if (v !== 32'h0000_8020) begin miscompares++; $display("[TB] FAIL unknown_mepc got %h want 00008020", v); end
    endtask

    task automatic test_backpressure();
        logic [31:0] er, erp, wd; logic erv, et;
        wd = $urandom;
        model(OP_CSRRW, 32'h0000_8030, 12'h342, wd, 1'b1, er, erv, erp, et);
        req_valid = 1; req_op = OP_CSRRW; req_pc = 32'h0000_8030;
        req_csr_addr = 12'h342; req_wdata = wd; req_csr_we = 1;
        @(posedge clk); #1;
        req_valid = 0; req_wdata = ~wd;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            vectors += 4;
            if (resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_resp_valid cycle %0d got %b want 1", i, resp_valid); end
            if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_ready cycle %0d got %b want 0", i, req_ready); end
            if (resp_rdata !== er) begin miscompares++; $display("[TB] FAIL bp_rdata cycle %0d got %h want %h", i, resp_rdata, er); end
            if (trap_taken !== 1'b0 || redirect_valid !== 1'b0) begin
                miscompares++; $display("[TB] FAIL bp_flags cycle %0d got trap=%b redir=%b want 0 0", i, trap_taken, redirect_valid);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        vectors += 2;
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release_resp_valid got %b want 0", resp_valid); end
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v;
        req_valid = 1; req_op = OP_CSRRW; req_pc = 32'h0000_8040;
        req_csr_addr = 12'h305; req_wdata = 32'h1234_5678; req_csr_we = 1;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 1;
        #2;
        rst = 0;
        model_reset();
        vectors += 2;
        if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_req_ready got %b want 1", req_ready); end
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_resp_valid got %b want 0", resp_valid); end
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle_resp_valid got %b want 0", resp_valid); end
        read_csr(12'h305, v);
        vectors++;
        if (v !== 32'h0000_8000) begin miscompares++; $display("[TB] FAIL midrst_mtvec got %h want 00008000", v); end
    endtask

    task automatic test_random();
        logic [31:0] er, erp, orr, orp, pc, wd; logic erv, et, orv, ot, we; int lat;
        logic [2:0] op; logic [11:0] addr;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: addr = 12'h305;
                1: addr = 12'h341;
                2: addr = 12'h342;
                3: addr = 12'h300;
                default: addr = 12'($urandom);
            endcase
            if (op <= 3'd2 && $urandom_range(0, 3) != 0)
                addr = (addr == 12'h300) ? 12'h342 : addr;
            pc = $urandom; wd = $urandom; we = 1'($urandom);
            model(op, pc, addr, wd, we, er, erv, erp, et);
            run_req(op, pc, addr, wd, we, lat, orr, orv, orp, ot);
            vectors += 5;
            if (lat !== 2) begin miscompares++; $display("[TB] FAIL rand%0d_latency got %0d want 2", n, lat); end
            if (orr !== er) begin miscompares++; $display("[TB] FAIL rand%0d_rdata op=%0d addr=%h got %h want %h", n, op, addr, orr, er); end
            if (orv !== erv) begin miscompares++; $display("[TB] FAIL rand%0d_redirect_valid op=%0d got %b want %b", n, op, orv, erv); end
            if (orp !== erp) begin miscompares++; $display("[TB] FAIL rand%0d_redirect_pc op=%0d got %h want %h", n, op, orp, erp); end
            if (ot !== et) begin miscompares++; $display("[TB] FAIL rand%0d_trap op=%0d addr=%h got %b want %b", n, op, addr, ot, et); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1; req_valid = 0; req_op = 0; req_pc = 0; req_csr_addr = 0;
        req_wdata = 0; req_csr_we = 0; resp_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_csrrw_mtvec();
        test_csrrs_no_write();
        test_ecall_mret();
        test_unknown_csr();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
